learn_sweep_sched: RTL and testbench

- Sequences the DDS frequency generator's learn mode for an automatic swept-frequency measurement.
- Raises learn_en and steps the tone with next_freq pulses. At each step it waits a settle time, requests one amplitude measurement, stores the result and tracks the peak.
- Sits between the control/key logic and the frequency controller (learn_en/next_freq consumer) plus the ADC amplitude-measurement block. Everything runs in the clk_50m domain.

---
 rtl/learn_sweep_sched_pkg.sv | 28 ++
 rtl/learn_sweep_sched_peak_track.sv | 33 +++
 rtl/learn_sweep_sched.sv | 160 ++++++++++++++++
 tb/tb_learn_sweep_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/learn_sweep_sched_pkg.sv
// Shared types, constants and helpers for the learn-mode sweep sequencer.
package learn_sweep_sched_pkg;

    // Default timing for a 50 MHz clock
    localparam int SETTLE_1MS   = 50000;
    localparam int MEAS_TO_40MS = 2000000;

    // One-hot sequencer states
    typedef enum logic [6:0] {
        S_IDLE   = 7'b000_0001,
        S_ENTER  = 7'b000_0010,
        S_SETTLE = 7'b000_0100,
        S_MEAS   = 7'b000_1000,
        S_STORE  = 7'b001_0000,
        S_STEP   = 7'b010_0000,
        S_FINISH = 7'b100_0000
    } sweep_state_t;

    // Step index width; at least one bit so a single-point sweep still has an address
    function automatic int step_idx_w(input int n_steps);
        return (n_steps > 1) ? $clog2(n_steps) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/learn_sweep_sched_peak_track.sv
// Peak tracker: remembers the largest stored amplitude of the current sweep and
// the step index where it was first seen.
module sweep_peak_track
    import learn_sweep_sched_pkg::*;
#(
    parameter int AMP_W = 16,
    parameter int IDX_W = 6
) (
    input  logic             clk_50m,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [AMP_W-1:0] amp,
    input  logic [IDX_W-1:0] idx,
    output logic [AMP_W-1:0] peak_amp,
    output logic [IDX_W-1:0] peak_idx
);

    // Clear at sweep start; strictly-greater compare keeps the earliest index on ties
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            peak_amp <= '0;
            peak_idx <= '0;
        end else if (clr) begin
            peak_amp <= '0;
            peak_idx <= '0;
        end else if (upd && (amp > peak_amp)) begin
            peak_amp <= amp;
            peak_idx <= idx;
        end
    end

endmodule

// File: rtl/learn_sweep_sched.sv
// Learn-mode sweep sequencer: enables learn mode, steps the DDS tone, waits for
// settling, requests one amplitude measurement per step, stores it and tracks the peak.
module learn_sweep_sched
    import learn_sweep_sched_pkg::*;
#(
    parameter int N_STEPS    = 50,
    parameter int SETTLE_CYC = SETTLE_1MS,
    parameter int ENTER_CYC  = 16,
    parameter int NF_HIGH    = 4,
    parameter int MEAS_TO    = MEAS_TO_40MS,
    parameter int AMP_W      = 16
) (
    input  logic                              clk_50m,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    output logic                              learn_en,
    output logic                              next_freq,
    output logic                              meas_start,
    input  logic                              meas_valid,
    input  logic [AMP_W-1:0]                  meas_amp,
    output logic                              wr_en,
    output logic [step_idx_w(N_STEPS)-1:0]    wr_addr,
    output logic [AMP_W-1:0]                  wr_data,
    output logic                              busy,
    output logic                              done,
    output logic [AMP_W-1:0]                  peak_amp,
    output logic [step_idx_w(N_STEPS)-1:0]    peak_idx,
    output logic                              to_err
);

    localparam int IDX_W   = step_idx_w(N_STEPS);
    localparam int CNT_MAX = max_int(max_int(SETTLE_CYC, MEAS_TO), max_int(ENTER_CYC, NF_HIGH + 1));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_STEPS - 1);
    localparam logic [CNT_W-1:0] ENTER_LAST = CNT_W'(ENTER_CYC - 1);
    localparam logic [CNT_W-1:0] SETL_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST  = CNT_W'(MEAS_TO - 1);
    localparam logic [CNT_W-1:0] NF_CYC     = CNT_W'(NF_HIGH);

    sweep_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [AMP_W-1:0] amp_q;
    logic             to_err_q;

    logic sweep_go;
    logic meas_take;
    logic meas_timeout;
    logic step_exit;

    assign sweep_go     = (state_q == S_IDLE) && start && !abort;
    assign meas_take    = (state_q == S_MEAS) && (state_d == S_STORE);
    assign meas_timeout = meas_take && !meas_valid;
    assign step_exit    = (state_q == S_STEP) && (state_d == S_SETTLE);

    // State register
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and Moore outputs; abort overrides everything, including start in IDLE
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        learn_en   = 1'b0;
        busy       = 1'b0;
        next_freq  = 1'b0;
        meas_start = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ENTER;
            end
            S_ENTER: begin
                learn_en = 1'b1;
                busy     = 1'b1;
                if (cnt_q == ENTER_LAST) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                learn_en = 1'b1;
                busy     = 1'b1;
                if (cnt_q == SETL_LAST) state_d = S_MEAS;
            end
            S_MEAS: begin
                learn_en   = 1'b1;
                busy       = 1'b1;
                meas_start = (cnt_q == '0);
                if (meas_valid || (cnt_q == MEAS_LAST)) state_d = S_STORE;
            end
            S_STORE: begin
                learn_en = 1'b1;
                busy     = 1'b1;
                wr_en    = 1'b1;
                state_d  = (idx_q == LAST_IDX) ? S_FINISH : S_STEP;
            end
            S_STEP: begin
                learn_en  = 1'b1;
                busy      = 1'b1;
                next_freq = (cnt_q < NF_CYC);
                if (cnt_q == NF_CYC) state_d = S_SETTLE;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Shared cycle counter: restarts on every state entry, parked at zero in IDLE
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst)                                          cnt_q <= '0;
        else if ((state_d != state_q) || (state_q == S_IDLE)) cnt_q <= '0;
        else                                              cnt_q <= cnt_q + 1'b1;
    end

    // Step index: cleared on start, advanced when STEP hands over to SETTLE
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst)            idx_q <= '0;
        else if (sweep_go)  idx_q <= '0;
        else if (step_exit) idx_q <= idx_q + 1'b1;
    end

    // Measurement latch and sticky timeout flag
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            amp_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (meas_take)         amp_q    <= meas_valid ? meas_amp : '0;
            if (sweep_go)          to_err_q <= 1'b0;
            else if (meas_timeout) to_err_q <= 1'b1;
        end
    end

    assign wr_addr = idx_q;
    assign wr_data = amp_q;
    assign to_err  = to_err_q;

    sweep_peak_track #(
        .AMP_W (AMP_W),
        .IDX_W (IDX_W)
    ) u_peak (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .clr      (sweep_go),
        .upd      (wr_en),
        .amp      (amp_q),
        .idx      (idx_q),
        .peak_amp (peak_amp),
        .peak_idx (peak_idx)
    );

endmodule

// File: tb/tb_learn_sweep_sched.sv
// Self-checking bench for learn_sweep_sched: directed and randomized sweeps
// against a behavioural model of expected writes, pulses, timing and peak.
module tb_learn_sweep_sched;

    localparam int N       = 5;
    localparam int SETTLE  = 20;
    localparam int ENTER   = 4;
    localparam int NFH     = 4;
    localparam int MTO     = 100;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic        resp_valid = 1'b0, stray_valid = 1'b0, meas_valid;
    logic [15:0] meas_amp = '0;
    logic        learn_en, next_freq, meas_start, wr_en, busy, done, to_err;
    logic [2:0]  wr_addr, peak_idx;
    logic [15:0] wr_data, peak_amp;

    logic        start1 = 1'b0, meas_valid1 = 1'b0;
    logic [15:0] meas_amp1 = 16'hBEEF;
    logic        learn_en1, next_freq1, meas_start1, wr_en1, busy1, done1, to_err1;
    logic [0:0]  wr_addr1, peak_idx1;
    logic [15:0] wr_data1, peak_amp1;

    assign meas_valid = resp_valid | stray_valid;

    learn_sweep_sched #(.N_STEPS(N), .SETTLE_CYC(SETTLE), .ENTER_CYC(ENTER), .NF_HIGH(NFH),
                        .MEAS_TO(MTO), .AMP_W(16)) u_dut (
        .clk_50m(clk_50m), .rst(rst), .start(start), .abort(abort),
        .learn_en(learn_en), .next_freq(next_freq), .meas_start(meas_start),
        .meas_valid(meas_valid), .meas_amp(meas_amp), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .peak_amp(peak_amp),
        .peak_idx(peak_idx), .to_err(to_err));

    learn_sweep_sched #(.N_STEPS(1), .SETTLE_CYC(SETTLE), .ENTER_CYC(ENTER), .NF_HIGH(NFH),
                        .MEAS_TO(MTO), .AMP_W(16)) u_dut1 (
        .clk_50m(clk_50m), .rst(rst), .start(start1), .abort(1'b0),
        .learn_en(learn_en1), .next_freq(next_freq1), .meas_start(meas_start1),
        .meas_valid(meas_valid1), .meas_amp(meas_amp1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .busy(busy1), .done(done1), .peak_amp(peak_amp1),
        .peak_idx(peak_idx1), .to_err(to_err1));

    always #10 clk_50m = ~clk_50m;

    int checks = 0, errors = 0;
    int cyc = 0, cs = 0;

    // stimulus controls read by the responder
    logic [15:0] amps [N];
    bit          no_resp [N];
    int          resp_delay = 10;
    logic [15:0] resp_amp = '0;
    int          resp_cnt = 0, ms_k = 0;

    // monitor records
    int clr_seq = 0, clr_seen = 0;
    int wa_q[$], wd_q[$], wc_q[$], nf_rise_q[$], nf_w_q[$], ms_q[$];
    int nf_len = 0, done_cnt = 0, done_cyc = -1, le_rise = -1, le_fall = -1;
    logic nf_prev = 1'b0, le_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk_50m) cyc++;

    // Monitor of DUT outputs plus the measurement responder, both away from the active edge
    always @(negedge clk_50m) begin
        if (clr_seq != clr_seen) begin
            clr_seen = clr_seq;
            wa_q.delete(); wd_q.delete(); wc_q.delete();
            nf_rise_q.delete(); nf_w_q.delete(); ms_q.delete();
            nf_len = 0; done_cnt = 0; done_cyc = -1; le_rise = -1; le_fall = -1;
            resp_cnt = 0; nf_prev = 1'b0; le_prev = learn_en;
        end
        if (wr_en) begin wa_q.push_back(int'(wr_addr)); wd_q.push_back(int'(wr_data)); wc_q.push_back(cyc); end
        if (next_freq && !nf_prev) begin nf_rise_q.push_back(cyc); nf_len = 0; end
        if (next_freq) nf_len++;
        if (!next_freq && nf_prev) nf_w_q.push_back(nf_len);
        nf_prev = next_freq;
        if (learn_en && !le_prev) le_rise = cyc;
        if (!learn_en && le_prev) le_fall = cyc;
        le_prev = learn_en;
        if (done) begin done_cnt++; done_cyc = cyc; end

        resp_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_valid = 1'b1;
        end
        if (meas_start) begin
            ms_q.push_back(cyc);
            ms_k = ms_q.size() - 1;
            if (ms_k < N && !no_resp[ms_k]) begin
                resp_cnt = resp_delay;
                resp_amp = amps[ms_k];
            end
        end
        meas_amp = resp_valid ? resp_amp : 16'($urandom);
    end

    // One full sweep; extra is the loop cycle at which a stray start is pulsed while busy
    task automatic run_sweep(input string nm, input int dly, input int extra);
        int k;
        int exp_d [N];
        int pk, pi, te, lat;
        clr_seq++;
        resp_delay = dly;
        @(negedge clk_50m); start = 1'b1; cs = cyc;
        @(negedge clk_50m); start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge clk_50m);
            start = (k == extra);
            k++;
            #1;
        end
        start = 1'b0;
        repeat (3) @(negedge clk_50m);
        #1;
        // reference: stored data, first strict maximum, any timeout
        pk = 0; pi = 0; te = 0;
        for (int i = 0; i < N; i++) begin
            exp_d[i] = no_resp[i] ? 0 : int'(amps[i]);
            if (no_resp[i]) te = 1;
            if (exp_d[i] > pk) begin pk = exp_d[i]; pi = i; end
        end
        check($sformatf("%s_done_cnt", nm), done_cnt, 1);
        check($sformatf("%s_n_writes", nm), wa_q.size(), N);
        for (int i = 0; i < N && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", nm, i), wa_q[i], i);
            check($sformatf("%s_data%0d", nm, i), wd_q[i], exp_d[i]);
            if (i < ms_q.size()) begin
                lat = no_resp[i] ? MTO : dly + 1;
                check($sformatf("%s_wr_time%0d", nm, i), wc_q[i], ms_q[i] + lat);
            end
        end
        check($sformatf("%s_n_nf", nm), nf_rise_q.size(), N - 1);
        for (int i = 0; i < nf_w_q.size(); i++)
            check($sformatf("%s_nf_w%0d", nm, i), nf_w_q[i], NFH);
        check($sformatf("%s_n_meas", nm), ms_q.size(), N);
        for (int i = 0; i < ms_q.size(); i++) begin
            if (i == 0)
                check($sformatf("%s_ms_time0", nm), ms_q[0], cs + 1 + ENTER + SETTLE);
            else if (i - 1 < nf_rise_q.size())
                check($sformatf("%s_ms_time%0d", nm, i), ms_q[i], nf_rise_q[i-1] + NFH + 1 + SETTLE);
        end
        check($sformatf("%s_le_rise", nm), le_rise, cs + 1);
        check($sformatf("%s_le_fall", nm), le_fall, done_cyc);
        check($sformatf("%s_peak_amp", nm), peak_amp, pk);
        check($sformatf("%s_peak_idx", nm), peak_idx, pi);
        check($sformatf("%s_to_err", nm), to_err, te);
        check($sformatf("%s_busy_end", nm), busy, 0);
    endtask

    task automatic set_amps(input int a0, input int a1, input int a2, input int a3, input int a4);
        amps[0] = 16'(a0); amps[1] = 16'(a1); amps[2] = 16'(a2); amps[3] = 16'(a3); amps[4] = 16'(a4);
        for (int i = 0; i < N; i++) no_resp[i] = 0;
    endtask

    task automatic wait_until_q(input string nm, input int which, input int target);
        int k;
        k = 0;
        while (k < 2000 && ((which == 0) ? nf_w_q.size() : ms_q.size()) < target) begin
            @(negedge clk_50m); #1; k++;
        end
        check($sformatf("%s_reached", nm), (k < 2000), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wr1, n_nf1, n_done1;
        logic ms1_prev;
        int wa1, wd1;

        for (int i = 0; i < N; i++) begin amps[i] = '0; no_resp[i] = 0; end
        repeat (3) @(negedge clk_50m);
        check("rst_outs", {learn_en, next_freq, meas_start, wr_en, busy, done, to_err,
                           wr_addr, wr_data, peak_amp, peak_idx}, 0);
        check("rst_outs1", {learn_en1, busy1, done1, wr_en1, peak_amp1}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_50m);

        // normal sweep with a start pulse while busy
        set_amps(100, 300, 700, 700, 200);
        run_sweep("norm", 10, 40);

        // timeout at step 1
        set_amps(100, 300, 700, 700, 200);
        no_resp[1] = 1;
        run_sweep("tmo", 10, 1000);

        // abort and start together while idle
        @(negedge clk_50m); start = 1'b1; abort = 1'b1;
        @(negedge clk_50m); start = 1'b0; abort = 1'b0;
        #1 check("abst_busy", busy, 0);
        repeat (5) @(negedge clk_50m);
        check("abst_le", learn_en, 0);

        // abort in the second SETTLE, with a stray meas_valid before it
        set_amps(1234, 50, 60, 70, 80);
        clr_seq++;
        resp_delay = 10;
        @(negedge clk_50m); start = 1'b1;
        @(negedge clk_50m); start = 1'b0;
        wait_until_q("ab_step", 0, 1);
        repeat (2) @(negedge clk_50m);
        stray_valid = 1'b1;
        @(negedge clk_50m);
        stray_valid = 1'b0;
        abort = 1'b1;
        #1 check("ab_pre_le", learn_en, 1);
        @(negedge clk_50m);
        abort = 1'b0;
        #1 check("ab_le", learn_en, 0);
        check("ab_busy", busy, 0);
        repeat (80) @(negedge clk_50m);
        #1 check("ab_writes", wa_q.size(), 1);
        check("ab_nf", nf_rise_q.size(), 1);
        check("ab_done", done_cnt, 0);
        check("ab_meas", ms_q.size(), 1);
        check("ab_peak_hold", peak_amp, 1234);
        check("ab_le_late", learn_en, 0);
        set_amps(10, 20, 30, 40, 5);
        run_sweep("post_ab", 3, 1000);

        // randomized sweeps: random amplitudes with ties, random timeouts and latencies
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < N; j++) begin
                amps[j] = 16'($urandom);
                if (j > 0 && $urandom_range(0, 3) == 0) amps[j] = amps[$urandom_range(0, j - 1)];
                no_resp[j] = ($urandom_range(0, 5) == 0);
            end
            run_sweep($sformatf("rnd%0d", r), int'($urandom_range(1, 40)), int'($urandom_range(2, 120)));
        end

        // reset in the middle of a measurement
        set_amps(500, 200, 300, 100, 50);
        no_resp[1] = 1;
        clr_seq++;
        resp_delay = 7;
        @(negedge clk_50m); start = 1'b1;
        @(negedge clk_50m); start = 1'b0;
        wait_until_q("rstm_meas", 1, 3);
        check("rstm_pre_peak", peak_amp, 500);
        check("rstm_pre_err", to_err, 1);
        check("rstm_pre_ms", meas_start, 1);
        rst = 1'b1;
        #1 check("rstm_outs", {learn_en, next_freq, meas_start, wr_en, busy, done, to_err,
                               wr_addr, wr_data, peak_amp, peak_idx}, 0);
        repeat (2) @(negedge clk_50m);
        rst = 1'b0;
        repeat (2) @(negedge clk_50m);

        // single-point configuration
        n_wr1 = 0; n_nf1 = 0; n_done1 = 0; ms1_prev = 1'b0; wa1 = -1; wd1 = -1;
        start1 = 1'b1;
        @(negedge clk_50m); start1 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_50m);
            meas_valid1 = ms1_prev;
            ms1_prev = meas_start1;
            if (wr_en1) begin n_wr1++; wa1 = int'(wr_addr1); wd1 = int'(wr_data1); end
            if (next_freq1) n_nf1++;
            if (done1) n_done1++;
        end
        check("one_writes", n_wr1, 1);
        check("one_addr", wa1, 0);
        check("one_data", wd1, 16'hBEEF);
        check("one_nf", n_nf1, 0);
        check("one_done", n_done1, 1);
        check("one_peak", peak_amp1, 16'hBEEF);
        check("one_to_err", to_err1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
